// File: rtl/esc_pwm_pkg.sv
// Shared types and default timing constants for the esc_pwm RC pulse generator.
package esc_pwm_pkg;

  localparam int unsigned CMD_W              = 10;
  localparam int unsigned PWM_PERIOD         = 3000;
  localparam int unsigned PWM_MIN_WIDTH      = 988;
  localparam int unsigned PWM_TIMEOUT_FRAMES = 50;

  typedef logic [CMD_W-1:0] cmd_t;
  typedef logic [10:0]      width_t;

  typedef enum logic {
    FS_NORMAL,
    FS_TRIPPED
  } fs_state_t;

  // Same mapping as the receive-side decoder: width_us = MIN_WIDTH + cmd.
  function automatic width_t pulse_width(input width_t min_w, input cmd_t cmd);
    return min_w + width_t'(cmd);
  endfunction

endpackage

// File: rtl/esc_pwm_if.sv
// Command strobe and pulse outputs of one esc_pwm channel.
interface esc_pwm_if;
  import esc_pwm_pkg::*;

  cmd_t cmd_in;
  logic cmd_valid;
  logic pwm_out;
  logic frame_start;
  logic failsafe;

  modport master (output cmd_in, cmd_valid, input pwm_out, frame_start, failsafe);
  modport slave  (input cmd_in, cmd_valid, output pwm_out, frame_start, failsafe);

endinterface

// File: rtl/esc_pwm_frame.sv
// Frame counter 0..PERIOD-1; flags the boundary edge and registers frame_start.
module esc_pwm_frame
  import esc_pwm_pkg::*;
#(
  parameter  int unsigned PERIOD = PWM_PERIOD,
  localparam int unsigned CNT_W  = $clog2(PERIOD)
) (
  input  logic             clk_1M,
  input  logic             rst,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             boundary,
  output logic             frame_start
);

  logic [CNT_W-1:0] cnt;
  logic             run;

  // The first edge after reset is itself a boundary, so frame 0 starts there.
  always_comb begin
    boundary = !run || (cnt == CNT_W'(PERIOD - 1));
    cnt_nxt  = boundary ? '0 : cnt + CNT_W'(1);
  end

  always_ff @(posedge clk_1M or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      run         <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      run         <= 1'b1;
      frame_start <= boundary;
    end
  end

endmodule

// File: rtl/esc_pwm.sv
// RC/ESC PWM channel: width = MIN_WIDTH + cmd, one frame every PERIOD cycles.
// Optional command-timeout failsafe enabled by defining ESC_PWM_FAILSAFE_EN.
module esc_pwm
  import esc_pwm_pkg::*;
#(
  parameter int unsigned PERIOD         = PWM_PERIOD,
  parameter int unsigned MIN_WIDTH      = PWM_MIN_WIDTH,
  parameter int unsigned TIMEOUT_FRAMES = PWM_TIMEOUT_FRAMES
) (
  input logic      clk_1M,
  input logic      rst,
  esc_pwm_if.slave pwm_if
);

  localparam int unsigned CNT_W = $clog2(PERIOD);

  if (MIN_WIDTH + 1023 >= PERIOD) begin : g_bad_width
    $error("esc_pwm: MIN_WIDTH + 1023 must be below PERIOD");
  end
  if (TIMEOUT_FRAMES == 0) begin : g_bad_timeout
    $error("esc_pwm: TIMEOUT_FRAMES must be at least 1");
  end

  logic [CNT_W-1:0] cnt_nxt;
  logic             boundary;
  cmd_t             pending;
  cmd_t             active;
  cmd_t             active_nxt;
  width_t           width_nxt;
  logic             pwm_nxt;
  logic             force_zero;

  esc_pwm_frame #(.PERIOD(PERIOD)) u_frame (
    .clk_1M      (clk_1M),
    .rst         (rst),
    .cnt_nxt     (cnt_nxt),
    .boundary    (boundary),
    .frame_start (pwm_if.frame_start)
  );

`ifdef ESC_PWM_FAILSAFE_EN
  localparam int unsigned MISS_W = $clog2(TIMEOUT_FRAMES + 1);

  fs_state_t         fs_state;
  fs_state_t         fs_state_nxt;
  logic [MISS_W-1:0] miss;
  logic [MISS_W-1:0] miss_nxt;

  // A strobe always wins; otherwise each boundary counts a silent frame,
  // and once the count is saturated the boundary forces the zero command.
  always_comb begin
    fs_state_nxt = fs_state;
    miss_nxt     = miss;
    force_zero   = 1'b0;
    if (pwm_if.cmd_valid) begin
      miss_nxt     = '0;
      fs_state_nxt = FS_NORMAL;
    end else if (boundary) begin
      if (fs_state == FS_TRIPPED || miss == MISS_W'(TIMEOUT_FRAMES)) begin
        force_zero   = 1'b1;
        fs_state_nxt = FS_TRIPPED;
      end
      if (miss != MISS_W'(TIMEOUT_FRAMES))
        miss_nxt = miss + MISS_W'(1);
    end
  end

  always_ff @(posedge clk_1M or negedge rst) begin
    if (!rst) begin
      fs_state <= FS_NORMAL;
      miss     <= '0;
    end else begin
      fs_state <= fs_state_nxt;
      miss     <= miss_nxt;
    end
  end

  assign pwm_if.failsafe = (fs_state == FS_TRIPPED);
`else
  always_comb force_zero = 1'b0;

  assign pwm_if.failsafe = 1'b0;
`endif

  // pwm_out is registered from the next-cycle counter and command, so the
  // frame's first high cycle coincides with frame_start.
  always_comb begin
    active_nxt = active;
    if (boundary) begin
      if (pwm_if.cmd_valid)
        active_nxt = pwm_if.cmd_in;
      else if (force_zero)
        active_nxt = '0;
      else
        active_nxt = pending;
    end
    width_nxt = pulse_width(width_t'(MIN_WIDTH), active_nxt);
    pwm_nxt   = (32'(cnt_nxt) < 32'(width_nxt));
  end

  always_ff @(posedge clk_1M or negedge rst) begin
    if (!rst) begin
      pending        <= '0;
      active         <= '0;
      pwm_if.pwm_out <= 1'b0;
    end else begin
      if (pwm_if.cmd_valid)
        pending <= pwm_if.cmd_in;
      active         <= active_nxt;
      pwm_if.pwm_out <= pwm_nxt;
    end
  end

endmodule

// File: tb/tb_esc_pwm.sv
// Directed self-checking bench for esc_pwm; failsafe expectations follow ESC_PWM_FAILSAFE_EN.
`timescale 1ns/1ps
module tb_esc_pwm;
  import esc_pwm_pkg::*;

  logic clk_1M = 1'b0;
  logic rst    = 1'b0;
  int   total  = 0;
  int   bad    = 0;

`ifdef ESC_PWM_FAILSAFE_EN
  localparam bit FS_ON = 1'b1;
`else
  localparam bit FS_ON = 1'b0;
`endif
  localparam int TMO = 4;

  esc_pwm_if pwm_if ();

  esc_pwm #(
    .PERIOD         (3000),
    .MIN_WIDTH      (988),
    .TIMEOUT_FRAMES (TMO)
  ) dut (
    .clk_1M (clk_1M),
    .rst    (rst),
    .pwm_if (pwm_if)
  );

  always #500 clk_1M = ~clk_1M;

  // Entered at the negedge of frame cycle 0; returns at cycle 0 of the next frame.
  // Optionally strobes val at frame cycle inj. hi = -1 if the pulse is not contiguous.
  task automatic measure_frame(input int inj, input cmd_t val,
                               output int hi, output int len,
                               output logic fs_start, output logic fs_after,
                               output logic pulse_ok);
    bit low_seen = 1'b0;
    bit split    = 1'b0;
    hi       = 0;
    len      = 0;
    fs_start = pwm_if.failsafe;
    fs_after = 1'bx;
    pulse_ok = pwm_if.frame_start;
    for (int k = 0; k <= 4000; k++) begin
      if (k > 0 && pwm_if.frame_start) begin
        len = k;
        break;
      end
      if (inj >= 0 && k == inj + 1) fs_after = pwm_if.failsafe;
      if (pwm_if.pwm_out) begin
        if (low_seen) split = 1'b1;
        hi++;
      end else begin
        low_seen = 1'b1;
      end
      pwm_if.cmd_valid = (k == inj);
      pwm_if.cmd_in    = (k == inj) ? val : '0;
      @(negedge clk_1M);
    end
    pwm_if.cmd_valid = 1'b0;
    if (split) hi = -1;
  endtask

  task automatic do_reset();
    pwm_if.cmd_valid = 1'b0;
    pwm_if.cmd_in    = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk_1M);
    rst = 1'b1;
    @(negedge clk_1M);
  endtask

  task automatic test_reset();
    int hi, len;
    logic fs0, fs1, pok;
    pwm_if.cmd_valid = 1'b0;
    pwm_if.cmd_in    = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk_1M);
    total++;
    if ({pwm_if.pwm_out, pwm_if.frame_start, pwm_if.failsafe} !== 3'b000) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=000",
               {pwm_if.pwm_out, pwm_if.frame_start, pwm_if.failsafe});
    end
    rst = 1'b1;
    @(negedge clk_1M);
    total++;
    if ({pwm_if.pwm_out, pwm_if.frame_start} !== 2'b11) begin
      bad++;
      $display("FAIL first_frame_start got=%b want=11", {pwm_if.pwm_out, pwm_if.frame_start});
    end
    for (int f = 0; f < 2; f++) begin
      measure_frame(-1, '0, hi, len, fs0, fs1, pok);
      total++;
      if (hi !== 988 || len !== 3000 || pok !== 1'b1) begin
        bad++;
        $display("FAIL idle_frame%0d got hi=%0d len=%0d start=%b want hi=988 len=3000 start=1",
                 f, hi, len, pok);
      end
    end
  endtask

  task automatic test_mid_frame();
    int hi, len;
    logic fs0, fs1, pok;
    do_reset();
    measure_frame(700, 10'd512, hi, len, fs0, fs1, pok);
    total++;
    if (hi !== 988 || len !== 3000) begin
      bad++;
      $display("FAIL mid_frame_current got hi=%0d len=%0d want hi=988 len=3000", hi, len);
    end
    measure_frame(-1, '0, hi, len, fs0, fs1, pok);
    total++;
    if (hi !== 1500 || len !== 3000) begin
      bad++;
      $display("FAIL mid_frame_next got hi=%0d len=%0d want hi=1500 len=3000", hi, len);
    end
  endtask

  task automatic test_extremes();
    int hi, len;
    logic fs0, fs1, pok;
    measure_frame(100, 10'd1023, hi, len, fs0, fs1, pok);
    total++;
    if (hi !== 1500 || len !== 3000) begin
      bad++;
      $display("FAIL ext_hold got hi=%0d len=%0d want hi=1500 len=3000", hi, len);
    end
    measure_frame(2500, 10'd0, hi, len, fs0, fs1, pok);
    total++;
    if (hi !== 2011 || len !== 3000) begin
      bad++;
      $display("FAIL ext_max got hi=%0d len=%0d want hi=2011 len=3000", hi, len);
    end
    measure_frame(-1, '0, hi, len, fs0, fs1, pok);
    total++;
    if (hi !== 988 || len !== 3000) begin
      bad++;
      $display("FAIL ext_min got hi=%0d len=%0d want hi=988 len=3000", hi, len);
    end
  endtask

  task automatic test_boundary();
    int hi, len;
    logic fs0, fs1, pok;
    measure_frame(2999, 10'd1012, hi, len, fs0, fs1, pok);
    total++;
    if (hi !== 988 || len !== 3000) begin
      bad++;
      $display("FAIL bypass_current got hi=%0d len=%0d want hi=988 len=3000", hi, len);
    end
    measure_frame(-1, '0, hi, len, fs0, fs1, pok);
    total++;
    if (hi !== 2000 || len !== 3000 || pok !== 1'b1) begin
      bad++;
      $display("FAIL bypass_next got hi=%0d len=%0d start=%b want hi=2000 len=3000 start=1",
               hi, len, pok);
    end
  endtask

  task automatic test_failsafe();
    int hi, len, exp_hi;
    logic fs0, fs1, pok, exp_fs;
    do_reset();
    measure_frame(100, 10'd512, hi, len, fs0, fs1, pok);
    for (int f = 1; f <= TMO + 1; f++) begin
      measure_frame(-1, '0, hi, len, fs0, fs1, pok);
      exp_hi = (FS_ON && f == TMO + 1) ? 988 : 1500;
      exp_fs = FS_ON && f == TMO + 1;
      total++;
      if (hi !== exp_hi || len !== 3000 || fs0 !== exp_fs) begin
        bad++;
        $display("FAIL timeout_frame%0d got hi=%0d len=%0d failsafe=%b want hi=%0d len=3000 failsafe=%b",
                 f, hi, len, fs0, exp_hi, exp_fs);
      end
    end
    measure_frame(1000, 10'd300, hi, len, fs0, fs1, pok);
    exp_hi = FS_ON ? 988 : 1500;
    total++;
    if (hi !== exp_hi || fs0 !== FS_ON || fs1 !== 1'b0) begin
      bad++;
      $display("FAIL recover_strobe got hi=%0d fs_start=%b fs_after=%b want hi=%0d fs_start=%b fs_after=0",
               hi, fs0, fs1, exp_hi, FS_ON);
    end
    measure_frame(-1, '0, hi, len, fs0, fs1, pok);
    total++;
    if (hi !== 1288 || len !== 3000 || fs0 !== 1'b0) begin
      bad++;
      $display("FAIL recover_frame got hi=%0d len=%0d failsafe=%b want hi=1288 len=3000 failsafe=0",
               hi, len, fs0);
    end
  endtask

  task automatic test_async_reset();
    int hi, len;
    logic fs0, fs1, pok;
    do_reset();
    measure_frame(100, 10'd512, hi, len, fs0, fs1, pok);
    repeat (500) @(negedge clk_1M);
    total++;
    if (pwm_if.pwm_out !== 1'b1) begin
      bad++;
      $display("FAIL pulse_before_reset got=%b want=1", pwm_if.pwm_out);
    end
    #200;
    rst = 1'b0;
    #1;
    total++;
    if ({pwm_if.pwm_out, pwm_if.frame_start, pwm_if.failsafe} !== 3'b000) begin
      bad++;
      $display("FAIL async_reset_drop got=%b want=000",
               {pwm_if.pwm_out, pwm_if.frame_start, pwm_if.failsafe});
    end
    repeat (2) @(negedge clk_1M);
    rst = 1'b1;
    @(negedge clk_1M);
    measure_frame(-1, '0, hi, len, fs0, fs1, pok);
    total++;
    if (hi !== 988 || len !== 3000 || pok !== 1'b1) begin
      bad++;
      $display("FAIL after_reset_frame got hi=%0d len=%0d start=%b want hi=988 len=3000 start=1",
               hi, len, pok);
    end
  endtask

  initial begin
    pwm_if.cmd_valid = 1'b0;
    pwm_if.cmd_in    = '0;
    test_reset();
    test_mid_frame();
    test_extremes();
    test_boundary();
    test_failsafe();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/esc_pwm.md
# esc_pwm

Servo/ESC pulse generator: converts a 10-bit command into a standard RC PWM frame on the `clk_1M` (1 µs) time base. It is the transmit-side counterpart of the radio pulse-width decoder and uses the same mapping, `width_us = 988 + cmd`, so a decoded command fed straight back reproduces the original pulse. It sits between the control logic and the motor/servo output pins, one instance per channel.

## Interface
- `PERIOD`, 3000: frame length in `clk_1M` cycles.
- `MIN_WIDTH`, 988: pulse width in cycles for `cmd = 0`.
- `TIMEOUT_FRAMES`, 50: frames without `cmd_valid` before failsafe trips. Used only with `ESC_PWM_FAILSAFE_EN`.
- `clk_1M`  in  1  1 MHz clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `cmd_in`  in  10  commanded value, 0..1023.
- `cmd_valid`  in  1  single-cycle strobe; captures `cmd_in`.
- `pwm_out`  out  1  PWM pulse, registered.
- `frame_start`  out  1  one-cycle pulse on the first cycle of each frame.
- `failsafe`  out  1  high while the command timeout is active. Tied to 0 without the macro.

## Operation
- Elaboration check: `MIN_WIDTH + 1023 < PERIOD`.
- Frame counter runs 0..PERIOD-1 and wraps. The wrap edge is the frame boundary.
- Pending register: loaded from `cmd_in` on any cycle with `cmd_valid`. The last strobe wins.
- Active register: loaded from pending at each frame boundary.
  - If `cmd_valid` is high in the boundary cycle (counter = PERIOD-1), active loads `cmd_in` directly (bypass).
  - The loaded value is applied to the frame that is starting.
- Width = `MIN_WIDTH + active`, an 11-bit unsigned add with no overflow possible; range 988..2011.
- `pwm_out` is high for exactly `width` cycles starting at frame cycle 0, then low for `PERIOD - width` cycles.
- A mid-frame `cmd_valid` never alters the current frame: no glitch, no truncation, no extension.
- Reset values: counter 0, pending 0, active 0, `pwm_out` 0, `frame_start` 0, `failsafe` 0.

## Timing
- The first frame starts on the first rising `clk_1M` edge after `rst` deasserts. `pwm_out` and `frame_start` go high after that edge.
- `frame_start` is high in the same cycle as the first high cycle of `pwm_out`, once every PERIOD cycles.
- Command latency:
  - `cmd_valid` at frame cycle c < PERIOD-1: takes effect at the next frame start, PERIOD-c cycles later.
  - `cmd_valid` at cycle PERIOD-1: takes effect one cycle later.
- Asynchronous reset mid-pulse: `pwm_out` drops to 0 immediately. Truncating the pulse is acceptable because low is the safe state. All state clears.

## Configuration
- `ESC_PWM_FAILSAFE_EN` defined:
  - A saturating frame counter increments at each boundary and clears on any `cmd_valid`.
  - After TIMEOUT_FRAMES consecutive complete frames with no strobe, the next boundary sets `failsafe=1` and forces active = 0 (width 988), overriding pending.
  - Active stays forced to 0 at every boundary while `failsafe=1`.
  - A `cmd_valid` clears `failsafe` in the following cycle. Its value is applied at the next boundary, or immediately if it lands in the boundary cycle.
- Macro undefined: no timeout logic; the last command repeats forever; `failsafe` is constant 0.

## Structure
- Package `esc_pwm_pkg`:
  - `CMD_W = 10`
  - `cmd_t` (`logic [9:0]`)
  - `width_t` (`logic [10:0]`)
  - default constants `PWM_PERIOD = 3000`, `PWM_MIN_WIDTH = 988`
- Sub-module `esc_pwm_frame`: frame counter plus boundary/`frame_start` generation, parameterised on PERIOD. The top level holds the command registers, width compare and failsafe.

## Test plan
- Reset release with no command → `pwm_out` high 988 cycles, low 2012, repeating every 3000. `frame_start` is a one-cycle pulse at each rise.
- `cmd_valid` with 512 at frame cycle 700 → current frame stays 988. Next frame is 1500 high / 1500 low.
- Commands 1023 then 0 on successive frames → pulse widths 2011 then 988. Period is exactly 3000 throughout.
- `cmd_valid` with 1012 at frame cycle 2999 → the frame starting next cycle is 2000 high.
- With `ESC_PWM_FAILSAFE_EN`:
  - 512, then no strobes → 50 frames of 1500, then frame 51 onward is 988 with `failsafe=1`.
  - Then strobe 300 → `failsafe=0` the next cycle; the next frame is 1288.
  - Without the macro, the same stimulus holds 1500 indefinitely with `failsafe=0`.
- `rst` asserted at cycle 500 of a 1500-cycle pulse → `pwm_out` 0 with no clock edge. Released → a fresh frame of width 988.
